// File: rtl/fir_tdm_mac.sv
// Folded FIR filter: one multiply-accumulate unit steps through N_TAPS taps per input sample.
// Coefficients can be loaded at runtime, and the output path applies selectable rounding and saturation.
module fir_tdm_mac #(
    parameter int COE_INTE_WL = 4,
    parameter int COE_FRAC_WL = 12,
    parameter int IN_INTE_WL  = 4,
    parameter int IN_FRAC_WL  = 12,
    parameter int OUT_INTE_WL = 4,
    parameter int OUT_FRAC_WL = 12,
    parameter int N_TAPS      = 30,
    parameter int ACC_GUARD   = 5,
    parameter int ROUND_EN    = 1,
    parameter int SAT_EN      = 1
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     coe_wr_en,
    input  logic [$clog2(N_TAPS)-1:0]                coe_wr_addr,
    input  logic [COE_INTE_WL+COE_FRAC_WL-1:0]       coe_wr_data,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [IN_INTE_WL+IN_FRAC_WL-1:0]         data_in,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [OUT_INTE_WL+OUT_FRAC_WL-1:0]       data_out,
    output logic                                     overflow
);
    localparam int CW = COE_INTE_WL + COE_FRAC_WL;
    localparam int IW = IN_INTE_WL + IN_FRAC_WL;
    localparam int OW = OUT_INTE_WL + OUT_FRAC_WL;
    localparam int PF = COE_FRAC_WL + IN_FRAC_WL;
    localparam int PW = CW + IW;
    localparam int AW = PW + ACC_GUARD;
    localparam int SH = PF - OUT_FRAC_WL;
    localparam int AB = $clog2(N_TAPS);
    localparam int RS = (SH > 0) ? SH - 1 : 0;
    localparam logic [AW-1:0] RND = (ROUND_EN != 0 && SH > 0) ? (AW'(1) << RS) : '0;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // in_ready is high only in IDLE. Once out_valid is high, data_out and overflow are held until out_ready.
    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
    state_t state;

    logic signed [IW-1:0] delay [N_TAPS];
    logic signed [CW-1:0] coe   [N_TAPS];
    logic [AB-1:0]        wr_ptr;
    logic [AB-1:0]        k;
    logic [AB-1:0]        rd_idx;
    logic [AB:0]          wrap_idx;
    logic signed [AW-1:0] acc;
    logic signed [PW-1:0] prod;
    logic signed [AW-1:0] acc_next;
    logic signed [AW-1:0] rounded;
    logic signed [AW-1:0] shifted;
    logic [AW-OW:0]       hi_bits;
    logic                 res_ovf;
    logic [OW-1:0]        res;

    // Newest sample sits at wr_ptr; tap k reads the sample k steps older.
    always_comb begin
        wrap_idx = {1'b0, wr_ptr} + (AB+1)'(N_TAPS) - {1'b0, k};
        rd_idx   = (wr_ptr >= k) ? (wr_ptr - k) : wrap_idx[AB-1:0];
        prod     = coe[k] * delay[rd_idx];
        acc_next = acc + {{ACC_GUARD{prod[PW-1]}}, prod};
    end

    // The bits above the output sign bit must all match it, otherwise the result does not fit.
    always_comb begin
        rounded = acc + RND;
        shifted = rounded >>> SH;
        hi_bits = shifted[AW-1:OW-1];
        res_ovf = !((&hi_bits) || !(|hi_bits));
        res     = shifted[OW-1:0];
        if (res_ovf && SAT_EN != 0)
            res = shifted[AW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            data_out  <= '0;
            overflow  <= 1'b0;
            wr_ptr    <= '0;
            k         <= '0;
            acc       <= '0;
            for (int i = 0; i < N_TAPS; i++) begin
                delay[i] <= '0;
                coe[i]   <= '0;
            end
        end else begin
            // A write in the same cycle as a sample accept is already visible at tap 0.
            if (coe_wr_en && state == IDLE && 32'(coe_wr_addr) < N_TAPS)
                coe[coe_wr_addr] <= coe_wr_data;
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        delay[wr_ptr] <= data_in;
                        acc           <= '0;
                        k             <= '0;
                        in_ready      <= 1'b0;
                        state         <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc_next;
                    if (k == AB'(N_TAPS - 1)) begin
                        k      <= '0;
                        wr_ptr <= (wr_ptr == AB'(N_TAPS - 1)) ? '0 : wr_ptr + 1'b1;
                        state  <= OUT;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                OUT: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        data_out  <= res;
                        overflow  <= res_ovf;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_tdm_mac.sv
// Bench for fir_tdm_mac: directed sample streams push their expected outputs into a queue.
// A negedge monitor pops one entry from that queue on every output handshake and compares it.
module tb_fir_tdm_mac;
    localparam int N = 30;

    logic        clk = 1'b0;
    logic        rst;
    logic        coe_wr_en;
    logic [4:0]  coe_wr_addr;
    logic [15:0] coe_wr_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] data_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] data_out;
    logic        overflow;

    logic [16:0] exp_q[$];
    logic [16:0] mon_e;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    fir_tdm_mac dut (
        .clk(clk), .rst(rst),
        .coe_wr_en(coe_wr_en), .coe_wr_addr(coe_wr_addr), .coe_wr_data(coe_wr_data),
        .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
        .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
        .overflow(overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: the transfer completes on the next rising edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %h, expected no output", data_out);
            end else begin
                mon_e = exp_q.pop_front();
                check("data_out", 32'(data_out), 32'(mon_e[15:0]));
                check("overflow", 32'(overflow), 32'(mon_e[16]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        coe_wr_en = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || !in_ready) && n < 500) begin
            step();
            n++;
        end
        if (n >= 500) begin
            checks++;
            errors++;
            $display("FAIL wait_idle_timeout: got %0d pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wr_coe(input int addr, input logic [15:0] val);
        coe_wr_en = 1'b1;
        coe_wr_addr = 5'(addr);
        coe_wr_data = val;
        step();
        coe_wr_en = 1'b0;
    endtask

    task automatic load_ramp();
        for (int i = 0; i < N; i++) wr_coe(i, 16'((i + 1) * 16));
    endtask

    task automatic load_const(input logic [15:0] val);
        for (int i = 0; i < N; i++) wr_coe(i, val);
    endtask

    task automatic send(input logic [15:0] d, input logic [16:0] e, input bit push);
        int n = 0;
        if (push) exp_q.push_back(e);
        in_valid = 1'b1;
        data_in = d;
        while (!in_ready && n < 500) begin
            step();
            n++;
        end
        if (n >= 500) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: got in_ready=%b, expected 1", in_ready);
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic impulse_run();
        send(16'h1000, 17'h00010, 1'b1);
        for (int n = 1; n < 32; n++)
            send(16'h0000, (n < N) ? 17'((n + 1) * 16) : 17'h0, 1'b1);
        wait_idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        coe_wr_en = 1'b0;
        coe_wr_addr = '0;
        coe_wr_data = '0;
        in_valid = 1'b0;
        data_in = '0;
        out_ready = 1'b1;
        do_reset();

        // Coefficients are all zero after reset.
        send(16'h1000, 17'h0, 1'b1);
        wait_idle();

        // Impulse response reproduces the coefficient ramp.
        do_reset();
        load_ramp();
        impulse_run();

        // Step response ramps up and settles at the sum of the taps.
        do_reset();
        load_const(16'h0100);
        for (int n = 0; n < 32; n++)
            send(16'h1000, (n < N) ? 17'((n + 1) * 256) : 17'h01E00, 1'b1);
        wait_idle();

        // Saturation at both rails.
        do_reset();
        load_const(16'h7FFF);
        for (int n = 0; n < 3; n++) send(16'h7FFF, 17'h17FFF, 1'b1);
        wait_idle();
        do_reset();
        load_const(16'h7FFF);
        for (int n = 0; n < 3; n++) send(16'h8000, 17'h18000, 1'b1);
        wait_idle();

        // Output back-pressure: result held, no new input accepted.
        do_reset();
        load_ramp();
        out_ready = 1'b0;
        send(16'h1000, 17'h00010, 1'b1);
        begin
            int n = 0;
            while (!out_valid && n < 100) begin
                step();
                n++;
            end
        end
        in_valid = 1'b1;
        data_in = 16'h0000;
        for (int i = 0; i < 20; i++) begin
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_data_out", 32'(data_out), 32'h0010);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            step();
        end
        out_ready = 1'b1;
        send(16'h0000, 17'h00020, 1'b1);
        wait_idle();

        // Coefficient writes outside IDLE and out of range are dropped.
        do_reset();
        load_ramp();
        send(16'h1000, 17'h00010, 1'b1);
        step();
        step();
        wr_coe(0, 16'h7000);
        send(16'h1000, 17'h00030, 1'b1);
        wait_idle();
        wr_coe(30, 16'h7000);
        coe_wr_en = 1'b1;
        coe_wr_addr = 5'd0;
        coe_wr_data = 16'h7000;
        send(16'h1000, 17'h07050, 1'b1);
        coe_wr_en = 1'b0;
        wait_idle();

        // Reset in the middle of MAC discards the partial result.
        do_reset();
        load_ramp();
        send(16'h1000, 17'h0, 1'b0);
        repeat (10) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < N + 6; i++) begin
            check("abort_out_valid", 32'(out_valid), 32'd0);
            step();
        end
        load_ramp();
        impulse_run();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
